// File: rtl/inst_queue_decode_if.sv
// Handshake bus between fetch (in_*) and the control unit (out_*) around the decode queue.
interface inst_queue_decode_if #(
   parameter int unsigned OPC_W = 5,
   parameter int unsigned REG_W = 4,
   parameter int unsigned INS_W = 19
);
   localparam int unsigned AW = INS_W - OPC_W;
   localparam int unsigned OW = INS_W - OPC_W - 2 * REG_W;

   logic             in_valid;
   logic             in_ready;
   logic [INS_W-1:0] in_ins;
   logic             out_valid;
   logic             out_ready;
   logic [OPC_W-1:0] out_opcode;
   logic [2:0]       out_fmt;
   logic [REG_W-1:0] out_rs1;
   logic [REG_W-1:0] out_rs2;
   logic [REG_W-1:0] out_rd;
   logic [AW-1:0]    out_addr_imm;
   logic [OW-1:0]    out_br_off;
   logic             out_illegal;

   modport slave (
      input  in_valid, in_ins, out_ready,
      output in_ready, out_valid, out_opcode, out_fmt, out_rs1, out_rs2, out_rd,
             out_addr_imm, out_br_off, out_illegal
   );

   modport master (
      output in_valid, in_ins, out_ready,
      input  in_ready, out_valid, out_opcode, out_fmt, out_rs1, out_rs2, out_rd,
             out_addr_imm, out_br_off, out_illegal
   );
endinterface

// File: rtl/inst_queue_decode.sv
// Instruction register with a DEPTH-entry decode queue: decodes at enqueue, presents the
// head entry to the control unit, and drops everything on a flush.
module inst_queue_decode #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned OPC_W = 5,
   parameter int unsigned REG_W = 4,
   parameter int unsigned INS_W = 19
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   inst_queue_decode_if.slave           bus,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int unsigned AW = INS_W - OPC_W;
   localparam int unsigned OW = INS_W - OPC_W - 2 * REG_W;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);

   localparam logic [2:0] FMT_R   = 3'd0;
   localparam logic [2:0] FMT_M   = 3'd1;
   localparam logic [2:0] FMT_B   = 3'd2;
   localparam logic [2:0] FMT_J   = 3'd3;
   localparam logic [2:0] FMT_N   = 3'd4;
   localparam logic [2:0] FMT_ILL = 3'd7;

   typedef struct packed {
      logic [OPC_W-1:0] opcode;
      logic [2:0]       fmt;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [REG_W-1:0] rd;
      logic [AW-1:0]    addr_imm;
      logic [OW-1:0]    br_off;
      logic             illegal;
   } entry_t;

   entry_t          mem_q [DEPTH];
   entry_t          dec_c;
   entry_t          head_c;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            push_c, pop_c;

   logic [OPC_W-1:0] opc_c;
   logic [REG_W-1:0] f1_c, f2_c, f3_c;

   assign opc_c = bus.in_ins[INS_W-1 -: OPC_W];
   assign f1_c  = bus.in_ins[INS_W-OPC_W-1 -: REG_W];
   assign f2_c  = bus.in_ins[INS_W-OPC_W-REG_W-1 -: REG_W];
   assign f3_c  = bus.in_ins[INS_W-OPC_W-2*REG_W-1 -: REG_W];

   // Per-format field extraction; fields a format does not use stay zero.
   always_comb begin
      dec_c        = '0;
      dec_c.opcode = opc_c;
      if (opc_c <= OPC_W'(9)) begin
         dec_c.fmt = FMT_R;
         dec_c.rs1 = f1_c;
         dec_c.rs2 = f2_c;
         dec_c.rd  = f3_c;
      end else if (opc_c == OPC_W'(10) || opc_c == OPC_W'(11)) begin
         dec_c.fmt      = FMT_M;
         dec_c.rs1      = f1_c;
         dec_c.rd       = f2_c;
         dec_c.addr_imm = AW'(bus.in_ins[OW-1:0]);
      end else if (opc_c == OPC_W'(14) || opc_c == OPC_W'(15)) begin
         dec_c.fmt    = FMT_B;
         dec_c.rs1    = f1_c;
         dec_c.rs2    = f2_c;
         dec_c.br_off = bus.in_ins[OW-1:0];
      end else if (opc_c == OPC_W'(13) || opc_c == OPC_W'(16)) begin
         dec_c.fmt      = FMT_J;
         dec_c.addr_imm = bus.in_ins[AW-1:0];
      end else if (opc_c == OPC_W'(17)) begin
         dec_c.fmt = FMT_N;
      end else begin
         dec_c.fmt     = FMT_ILL;
         dec_c.illegal = 1'b1;
      end
   end

   assign push_c = bus.in_valid && bus.in_ready && !flush;
   assign pop_c  = bus.out_valid && bus.out_ready && !flush;

   // Pointer and occupancy update; flush overrides any push or pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push_c) mem_q[wr_ptr_q] <= dec_c;
      end
   end

   assign head_c           = mem_q[rd_ptr_q];
   assign count            = count_q;
   assign bus.in_ready     = (count_q != CW'(DEPTH));
   assign bus.out_valid    = (count_q != '0);
   assign bus.out_opcode   = head_c.opcode;
   assign bus.out_fmt      = head_c.fmt;
   assign bus.out_rs1      = head_c.rs1;
   assign bus.out_rs2      = head_c.rs2;
   assign bus.out_rd       = head_c.rd;
   assign bus.out_addr_imm = head_c.addr_imm;
   assign bus.out_br_off   = head_c.br_off;
   assign bus.out_illegal  = head_c.illegal;
endmodule

// File: tb/tb_inst_queue_decode.sv
// Directed bench for inst_queue_decode: decode formats, ordering across wrap, flush, reset.
module tb_inst_queue_decode;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned OPC_W = 5;
   localparam int unsigned REG_W = 4;
   localparam int unsigned INS_W = 19;
   localparam int unsigned AW    = 14;
   localparam int unsigned OW    = 6;
   localparam int unsigned CW    = 3;
   localparam int unsigned HW    = 3 + OPC_W + 3 * REG_W + AW + OW + 1;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic [CW-1:0] count;
   int            total = 0;
   int            bad   = 0;

   inst_queue_decode_if #(.OPC_W(OPC_W), .REG_W(REG_W), .INS_W(INS_W)) bus ();

   inst_queue_decode #(.DEPTH(DEPTH), .OPC_W(OPC_W), .REG_W(REG_W), .INS_W(INS_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus),
      .count (count)
   );

   always #5 clk = ~clk;

   function automatic logic [HW-1:0] head();
      return {bus.out_fmt, bus.out_opcode, bus.out_rs1, bus.out_rs2, bus.out_rd,
              bus.out_addr_imm, bus.out_br_off, bus.out_illegal};
   endfunction

   function automatic logic [HW-1:0] ev(input logic [2:0] fmt, input logic [OPC_W-1:0] op,
                                        input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2,
                                        input logic [REG_W-1:0] rd, input logic [AW-1:0] ai,
                                        input logic [OW-1:0] bo, input logic ill);
      return {fmt, op, rs1, rs2, rd, ai, bo, ill};
   endfunction

   // R-format word used for the wrap test: opcode i%10, fields i+1, i+2, i+3.
   function automatic logic [INS_W-1:0] rword(input int i);
      return {OPC_W'(i % 10), REG_W'(i + 1), REG_W'(i + 2), REG_W'(i + 3), 2'b00};
   endfunction

   function automatic logic [HW-1:0] rexp(input int i);
      return ev(3'd0, OPC_W'(i % 10), REG_W'(i + 1), REG_W'(i + 2), REG_W'(i + 3), '0, '0, 1'b0);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [INS_W-1:0] w);
      bus.in_valid = 1'b1;
      bus.in_ins   = w;
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      bus.in_valid  = 1'b0;
      bus.in_ins    = '0;
      bus.out_ready = 1'b0;
      rst_n = 1'b0;
      step();
      step();
      total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got %0d want 0", count); end
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
      total++; if (head() !== '0) begin bad++; $display("FAIL reset_fields got %h want 0", head()); end
      rst_n = 1'b1;
      step();
      total++; if (count !== 3'd0) begin bad++; $display("FAIL idle_count got %0d want 0", count); end
   endtask

   task automatic test_r_format();
      push(19'b00001_0011_0101_1000_00);
      total++; if (count !== 3'd1) begin bad++; $display("FAIL r_count got %0d want 1", count); end
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL r_valid got %b want 1", bus.out_valid); end
      total++; if (head() !== ev(3'd0, 5'd1, 4'd3, 4'd5, 4'd8, '0, '0, 1'b0))
         begin bad++; $display("FAIL r_head got %h want %h", head(), ev(3'd0, 5'd1, 4'd3, 4'd5, 4'd8, '0, '0, 1'b0)); end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      total++; if (count !== 3'd0) begin bad++; $display("FAIL r_pop_count got %0d want 0", count); end
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL r_pop_valid got %b want 0", bus.out_valid); end
   endtask

   task automatic test_m_j();
      push(19'b01010_0010_0111_101101);
      push({5'b10000, 14'd9000});
      total++; if (count !== 3'd2) begin bad++; $display("FAIL mj_count got %0d want 2", count); end
      total++; if (head() !== ev(3'd1, 5'd10, 4'd2, 4'd0, 4'd7, 14'd45, '0, 1'b0))
         begin bad++; $display("FAIL m_head got %h want %h", head(), ev(3'd1, 5'd10, 4'd2, 4'd0, 4'd7, 14'd45, '0, 1'b0)); end
      step();
      total++; if (head() !== ev(3'd1, 5'd10, 4'd2, 4'd0, 4'd7, 14'd45, '0, 1'b0))
         begin bad++; $display("FAIL m_hold got %h", head()); end
      bus.out_ready = 1'b1;
      step();
      total++; if (head() !== ev(3'd3, 5'd16, '0, '0, '0, 14'd9000, '0, 1'b0))
         begin bad++; $display("FAIL j_head got %h want %h", head(), ev(3'd3, 5'd16, '0, '0, '0, 14'd9000, '0, 1'b0)); end
      total++; if (count !== 3'd1) begin bad++; $display("FAIL j_count got %0d want 1", count); end
      step();
      bus.out_ready = 1'b0;
      total++; if (count !== 3'd0) begin bad++; $display("FAIL mj_drain got %0d want 0", count); end
   endtask

   task automatic test_b_n();
      push({5'd14, 4'd9, 4'd4, 6'b110011});
      push({5'd17, 14'h1234});
      total++; if (head() !== ev(3'd2, 5'd14, 4'd9, 4'd4, 4'd0, '0, 6'd51, 1'b0))
         begin bad++; $display("FAIL b_head got %h want %h", head(), ev(3'd2, 5'd14, 4'd9, 4'd4, 4'd0, '0, 6'd51, 1'b0)); end
      bus.out_ready = 1'b1;
      step();
      total++; if (head() !== ev(3'd4, 5'd17, '0, '0, '0, '0, '0, 1'b0))
         begin bad++; $display("FAIL n_head got %h want %h", head(), ev(3'd4, 5'd17, '0, '0, '0, '0, '0, 1'b0)); end
      step();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_full_wrap();
      for (int i = 0; i < 4; i++) push(rword(i));
      total++; if (count !== 3'd4) begin bad++; $display("FAIL full_count got %0d want 4", count); end
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got %b want 0", bus.in_ready); end
      bus.in_valid = 1'b1;
      bus.in_ins   = rword(4);
      step();
      total++; if (count !== 3'd4) begin bad++; $display("FAIL full_reject got %0d want 4", count); end
      total++; if (head() !== rexp(0)) begin bad++; $display("FAIL full_head got %h want %h", head(), rexp(0)); end
      bus.out_ready = 1'b1;
      step();
      total++; if (count !== 3'd3) begin bad++; $display("FAIL full_pop got %0d want 3", count); end
      for (int k = 0; k < 10; k++) begin
         bus.in_ins = rword(4 + k);
         step();
         total++; if (count !== 3'd3) begin bad++; $display("FAIL wrap_count[%0d] got %0d want 3", k, count); end
         total++; if (head() !== rexp(k + 2))
            begin bad++; $display("FAIL wrap_head[%0d] got %h want %h", k, head(), rexp(k + 2)); end
      end
      bus.in_valid = 1'b0;
      step();
      total++; if (head() !== rexp(12)) begin bad++; $display("FAIL drain_head got %h want %h", head(), rexp(12)); end
      step();
      step();
      bus.out_ready = 1'b0;
      total++; if (count !== 3'd0) begin bad++; $display("FAIL drain_count got %0d want 0", count); end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) push(rword(i));
      bus.in_valid  = 1'b1;
      bus.in_ins    = rword(7);
      bus.out_ready = 1'b1;
      flush         = 1'b1;
      step();
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      total++; if (count !== 3'd0) begin bad++; $display("FAIL flush_count got %0d want 0", count); end
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got %b want 0", bus.out_valid); end
      push(rword(5));
      total++; if (count !== 3'd1) begin bad++; $display("FAIL post_flush_count got %0d want 1", count); end
      total++; if (head() !== rexp(5)) begin bad++; $display("FAIL post_flush_head got %h want %h", head(), rexp(5)); end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_illegal_reset();
      push({5'd12, 14'h3fff});
      push({5'd20, 14'h2aaa});
      total++; if (head() !== ev(3'd7, 5'd12, '0, '0, '0, '0, '0, 1'b1))
         begin bad++; $display("FAIL ill12_head got %h want %h", head(), ev(3'd7, 5'd12, '0, '0, '0, '0, '0, 1'b1)); end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      total++; if (head() !== ev(3'd7, 5'd20, '0, '0, '0, '0, '0, 1'b1))
         begin bad++; $display("FAIL ill20_head got %h want %h", head(), ev(3'd7, 5'd20, '0, '0, '0, '0, '0, 1'b1)); end
      push(rword(3));
      total++; if (count !== 3'd2) begin bad++; $display("FAIL pre_rst_count got %0d want 2", count); end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (count !== 3'd0) begin bad++; $display("FAIL async_rst_count got %0d want 0", count); end
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL async_rst_valid got %b want 0", bus.out_valid); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL async_rst_ready got %b want 1", bus.in_ready); end
      total++; if (head() !== '0) begin bad++; $display("FAIL async_rst_fields got %h want 0", head()); end
      step();
      rst_n = 1'b1;
      push(rword(6));
      total++; if (count !== 3'd1) begin bad++; $display("FAIL first_push_count got %0d want 1", count); end
      total++; if (head() !== rexp(6)) begin bad++; $display("FAIL first_push_head got %h want %h", head(), rexp(6)); end
   endtask

   initial begin
      test_reset();
      test_r_format();
      test_m_j();
      test_b_n();
      test_full_wrap();
      test_flush();
      test_illegal_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
